// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: segment bit positions and the 0-F glyph table.
// Glyphs are stored low-active (0 = segment lit), bit0 = a .. bit6 = g.
package seg7_pkg;

  localparam int SEG_COUNT = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [SEG_COUNT-1:0] SEG_ALL_OFF = '1;

  // Entry n is the glyph for nibble n; listed F down to 0 so the packed index matches.
  localparam logic [15:0][SEG_COUNT-1:0] SEG_PATTERNS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [SEG_COUNT-1:0] seg_pattern(input logic [3:0] nibble);
    return SEG_PATTERNS[nibble];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to low-active seven-segment glyph.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0]           nibble,
  output logic [SEG_COUNT-1:0] pattern
);

  assign pattern = seg_pattern(nibble);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with per-slot anti-ghost blanking and tear-free frames.
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [SEG_COUNT-1:0]    segmentos,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodos,
  output logic                    frame_start
);

  localparam int   IDX_W   = $clog2(NUM_DIGITS);
  localparam int   CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic OFF_LVL = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        prescale_cnt, prescale_cnt_next;
  logic [IDX_W-1:0]        scan_idx, scan_idx_next;
  logic                    primed, primed_next;
  logic                    tick, enter_frame;
  logic [4*NUM_DIGITS-1:0] snap_digits, snap_digits_next;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_next;
  logic [NUM_DIGITS-1:0]   snap_blank, snap_blank_next;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_nibble;
  logic                    cur_dp_req, cur_dark, cur_dp_dark;
  logic [SEG_COUNT-1:0]    glyph, seg_low_next;
  logic                    dp_low_next;
  logic [NUM_DIGITS-1:0]   anode_on_next;

  assign tick = (prescale_cnt == CNT_W'(PRESCALE - 1));

  // The first tick after reset lands on slot 0 rather than advancing, so a frame always starts cleanly.
  always_comb begin
    prescale_cnt_next = tick ? '0 : prescale_cnt + 1'b1;
    primed_next       = primed | tick;
    scan_idx_next     = scan_idx;
    if (tick) begin
      if (!primed || scan_idx == IDX_W'(NUM_DIGITS - 1))
        scan_idx_next = '0;
      else
        scan_idx_next = scan_idx + 1'b1;
    end
    enter_frame      = tick && (scan_idx_next == '0);
    snap_digits_next = enter_frame ? digits     : snap_digits;
    snap_dp_next     = enter_frame ? dp_in      : snap_dp;
    snap_blank_next  = enter_frame ? blank_mask : snap_blank;
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic zero_run;

  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (snap_digits_next[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    cur_nibble = '0;
    cur_dp_req = 1'b0;
    cur_dark   = 1'b0;
    cur_dp_dark = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_next == IDX_W'(i)) begin
        cur_nibble  = snap_digits_next[4*i +: 4];
        cur_dp_req  = snap_dp_next[i];
        cur_dark    = snap_blank_next[i] | lz_mask[i];
        cur_dp_dark = snap_blank_next[i];
      end
    end
  end

  seg7_decoder u_decoder (
    .nibble  (cur_nibble),
    .pattern (glyph)
  );

  // Outputs are computed from next-state so they reflect a new slot in the cycle right after its tick.
  always_comb begin
    seg_low_next  = (primed_next && !cur_dark) ? glyph : SEG_ALL_OFF;
    dp_low_next   = !(primed_next && cur_dp_req && !cur_dp_dark);
    anode_on_next = '0;
    if (primed_next && int'(prescale_cnt_next) >= BLANK_CYCLES)
      anode_on_next = NUM_DIGITS'(1) << scan_idx_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_cnt <= '0;
      scan_idx     <= '0;
      primed       <= 1'b0;
      snap_digits  <= '0;
      snap_dp      <= '0;
      snap_blank   <= '0;
      segmentos    <= {SEG_COUNT{OFF_LVL}};
      dp           <= OFF_LVL;
      anodos       <= {NUM_DIGITS{OFF_LVL}};
      frame_start  <= 1'b0;
    end else begin
      prescale_cnt <= prescale_cnt_next;
      scan_idx     <= scan_idx_next;
      primed       <= primed_next;
      snap_digits  <= snap_digits_next;
      snap_dp      <= snap_dp_next;
      snap_blank   <= snap_blank_next;
      segmentos    <= seg_low_next ^ {SEG_COUNT{~OFF_LVL}};
      dp           <= dp_low_next ^ ~OFF_LVL;
      anodos       <= anode_on_next ^ {NUM_DIGITS{OFF_LVL}};
      frame_start  <= enter_frame;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner (4-digit and 3-digit instances, PRESCALE=4, BLANK_CYCLES=1).
// Leading-zero expectations follow SEG7_LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [6:0]  segmentos;
  logic        dp;
  logic [3:0]  anodos;
  logic        frame_start;

  logic [11:0] digits3;
  logic [2:0]  dp_in3;
  logic [2:0]  blank_mask3;
  logic [6:0]  segmentos3;
  logic        dp3;
  logic [2:0]  anodos3;
  logic        frame_start3;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .dp_in       (dp_in),
    .blank_mask  (blank_mask),
    .segmentos   (segmentos),
    .dp          (dp),
    .anodos      (anodos),
    .frame_start (frame_start)
  );

  seven_seg_scanner #(
    .NUM_DIGITS(3), .PRESCALE(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1)
  ) dut3 (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits3),
    .dp_in       (dp_in3),
    .blank_mask  (blank_mask3),
    .segmentos   (segmentos3),
    .dp          (dp3),
    .anodos      (anodos3),
    .frame_start (frame_start3)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits     = d;
    dp_in      = p;
    blank_mask = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Entered sampled at slot 0 blank cycle; leaves sampled at the last cycle of slot 3.
  task automatic checkFrame(input string name, input logic [3:0][6:0] seg_tab, input logic [3:0] dp_tab);
    logic [3:0] exp_an;
    checkOutput({name, "_fs"}, 32'(frame_start), 32'd1);
    checkOutput({name, "_s0_blank_an"}, 32'(anodos), 32'hF);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) begin
        step();
        checkOutput($sformatf("%s_s%0d_blank_an", name, s), 32'(anodos), 32'hF);
        checkOutput($sformatf("%s_s%0d_fs", name, s), 32'(frame_start), 32'd0);
      end
      exp_an = ~(4'b0001 << s);
      for (int c = 1; c < 4; c++) begin
        step();
        checkOutput($sformatf("%s_s%0d_c%0d_an", name, s, c), 32'(anodos), 32'(exp_an));
        checkOutput($sformatf("%s_s%0d_c%0d_seg", name, s, c), 32'(segmentos), 32'(seg_tab[s]));
        checkOutput($sformatf("%s_s%0d_c%0d_dp", name, s, c), 32'(dp), 32'(dp_tab[s]));
      end
    end
  endtask

  initial begin
    logic [3:0][6:0] seg_tab;
    logic [2:0][6:0] seg_tab3;
    logic [2:0]      exp_an3;
    int              j, idx, c;

    $display("[TB] start");
    reset       = 1'b1;
    applyStimulus(16'h1234, 4'b0000, 4'b0000);
    digits3     = 12'h987;
    dp_in3      = 3'b000;
    blank_mask3 = 3'b000;
    @(negedge clk);
    checkOutput("rst_an", 32'(anodos), 32'hF);
    checkOutput("rst_seg", 32'(segmentos), 32'h7F);
    checkOutput("rst_dp", 32'(dp), 32'd1);
    checkOutput("rst_fs", 32'(frame_start), 32'd0);
    checkOutput("rst_an3", 32'(anodos3), 32'h7);
    reset = 1'b0;

    for (int k = 1; k <= 3; k++) begin
      step();
      checkOutput($sformatf("pre_k%0d_an", k), 32'(anodos), 32'hF);
      checkOutput($sformatf("pre_k%0d_fs", k), 32'(frame_start), 32'd0);
    end
    step();
    // Snapshot of 1234 was taken on that tick; changing inputs now must not tear this frame.
    applyStimulus(16'hABCD, 4'b0000, 4'b0000);
    seg_tab = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    checkFrame("f1234", seg_tab, 4'b1111);

    step();
    seg_tab = {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
    checkFrame("fABCD", seg_tab, 4'b1111);

    applyStimulus(16'h0050, 4'b0101, 4'b0000);
    step();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    seg_tab = {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000};
`else
    seg_tab = {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000};
`endif
    checkFrame("f0050", seg_tab, 4'b1010);

    applyStimulus(16'h86FE, 4'b0101, 4'b0100);
    step();
    seg_tab = {7'b0000000, 7'b1111111, 7'b0001110, 7'b0000110};
    checkFrame("f86FE", seg_tab, 4'b1110);

    step();
    step();
    checkOutput("mid_an", 32'(anodos), 32'hE);
    reset = 1'b1;
    #1;
    checkOutput("midrst_an", 32'(anodos), 32'hF);
    checkOutput("midrst_seg", 32'(segmentos), 32'h7F);
    checkOutput("midrst_dp", 32'(dp), 32'd1);
    checkOutput("midrst_fs", 32'(frame_start), 32'd0);
    checkOutput("midrst_an3", 32'(anodos3), 32'h7);
    step();
    reset = 1'b0;

    seg_tab3 = {7'b0010000, 7'b0000000, 7'b1111000};
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k <= 5) begin
        checkOutput($sformatf("rel_k%0d_an", k), 32'(anodos), (k < 5) ? 32'hF : 32'hE);
        checkOutput($sformatf("rel_k%0d_fs", k), 32'(frame_start), (k == 4) ? 32'd1 : 32'd0);
      end
      if (k == 5)
        checkOutput("rel_k5_seg", 32'(segmentos), 32'h06);
      j   = (k >= 4) ? (k - 4) / 4 : 0;
      idx = j % 3;
      c   = (k >= 4) ? (k - 4) % 4 : 0;
      exp_an3 = (k < 4 || c == 0) ? 3'b111 : ~(3'b001 << idx);
      checkOutput($sformatf("n3_k%0d_an", k), 32'(anodos3), 32'(exp_an3));
      checkOutput($sformatf("n3_k%0d_fs", k), 32'(frame_start3),
                  (k >= 4 && (k - 4) % 12 == 0) ? 32'd1 : 32'd0);
      if (k >= 4 && c != 0) begin
        checkOutput($sformatf("n3_k%0d_seg", k), 32'(segmentos3), 32'(seg_tab3[idx]));
        checkOutput($sformatf("n3_k%0d_dp", k), 32'(dp3), 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
